// File: rtl/pix_framer.sv
// Pixel framer: buffers a valid/ready pixel stream in a small FIFO and emits a framed
// ima/enable stream with frame/line markers and a fixed horizontal-blanking gap per line.
module pix_framer #(
  parameter int IMA        = 8,
  parameter int COLS       = 32,
  parameter int ROWS       = 7,
  parameter int HBLANK     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IMA-1:0] pix_in,
  input  logic           pix_sof,
  input  logic           pix_valid,
  output logic           pix_ready,
  output logic [IMA-1:0] ima,
  output logic           enable,
  output logic           frame_start,
  output logic           line_start,
  output logic           frame_end,
  output logic           sync_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK + 1) : 1;

  typedef enum logic [1:0] {S_WAIT, S_ACT, S_BLANK} state_t;

  // FIFO of {sof, pixel}; pointers carry one extra wrap bit for full/empty
  logic [IMA:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]    r_wptr, r_rptr;
  logic           w_full, w_empty, w_push, w_pop;
  logic [IMA:0]   w_head;
  logic           w_sof;
  logic [IMA-1:0] w_dat;

  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign pix_ready = ~w_full & ~rst;
  assign w_push    = pix_valid & pix_ready;
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign w_sof     = w_head[IMA];
  assign w_dat     = w_head[IMA-1:0];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= {pix_sof, pix_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_col, w_col_n, w_pc;
  logic [RW-1:0] r_row, w_row_n, w_pr;
  logic [BW-1:0] r_cnt, w_cnt_n;
  logic          r_eof, w_eof_n;
  logic          w_take, w_last_col, w_last_row;

  assign w_pop      = ~w_empty && (r_state != S_BLANK);
  // A sof entry always restarts the frame at (0,0), whatever the counters say
  assign w_take     = w_pop && (w_sof || r_state == S_ACT);
  assign w_pc       = w_sof ? '0 : r_col;
  assign w_pr       = w_sof ? '0 : r_row;
  assign w_last_col = (w_pc == CW'(COLS - 1));
  assign w_last_row = (w_pr == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_eof   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_cnt   <= w_cnt_n;
      r_eof   <= w_eof_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_col_n   = r_col;
    w_row_n   = r_row;
    w_cnt_n   = r_cnt;
    w_eof_n   = r_eof;
    case (r_state)
      S_BLANK: begin
        w_cnt_n = r_cnt - BW'(1);
        if (r_cnt == BW'(1)) w_state_n = r_eof ? S_WAIT : S_ACT;
      end
      default: begin
        if (w_take) begin
          if (w_last_col) begin
            w_col_n = '0;
            w_row_n = w_last_row ? '0 : w_pr + RW'(1);
            w_eof_n = w_last_row;
            if (HBLANK > 0) begin
              w_state_n = S_BLANK;
              w_cnt_n   = BW'(HBLANK);
            end else begin
              w_state_n = w_last_row ? S_WAIT : S_ACT;
            end
          end else begin
            w_col_n   = w_pc + CW'(1);
            w_row_n   = w_pr;
            w_state_n = S_ACT;
          end
        end
      end
    endcase
  end

  logic w_fs, w_ls, w_fe, w_se;

  always_comb begin
    w_ls = w_take && (w_pc == '0);
    w_fs = w_ls && (w_pr == '0);
    w_fe = w_take && w_last_col && w_last_row;
    w_se = w_take && (r_state == S_ACT) && w_sof && ((r_col != '0) || (r_row != '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ima         <= '0;
      enable      <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      frame_end   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (w_take) ima <= w_dat;
      enable      <= w_take;
      frame_start <= w_fs;
      line_start  <= w_ls;
      frame_end   <= w_fe;
      sync_err    <= w_se;
    end
  end

endmodule

// File: tb/tb_pix_framer.sv
// Directed bench for pix_framer: default geometry on instance A, a 4x2 no-blanking
// geometry on instance B; outputs are recorded every falling edge and checked per scenario.
module tb_pix_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_pix, a_ima, b_pix, b_ima;
  logic a_sof, a_valid, a_rdy, a_en, a_fs, a_ls, a_fe, a_se;
  logic b_sof, b_valid, b_rdy, b_en, b_fs, b_ls, b_fe, b_se;

  pix_framer u_a (
    .clk(clk), .rst(rst), .pix_in(a_pix), .pix_sof(a_sof), .pix_valid(a_valid),
    .pix_ready(a_rdy), .ima(a_ima), .enable(a_en), .frame_start(a_fs),
    .line_start(a_ls), .frame_end(a_fe), .sync_err(a_se)
  );

  pix_framer #(.IMA(8), .COLS(4), .ROWS(2), .HBLANK(0), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .pix_in(b_pix), .pix_sof(b_sof), .pix_valid(b_valid),
    .pix_ready(b_rdy), .ima(b_ima), .enable(b_en), .frame_start(b_fs),
    .line_start(b_ls), .frame_end(b_fe), .sync_err(b_se)
  );

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       fs, ls, fe, se, rdy;
    int         cyc;
  } rec_t;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rec_on = 1'b0;
  rec_t qa[$];
  rec_t qb[$];
  int   epos[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rec_on) begin
      qa.push_back('{a_en, a_ima, a_fs, a_ls, a_fe, a_se, a_rdy, cyc});
      qb.push_back('{b_en, b_ima, b_fs, b_ls, b_fe, b_se, b_rdy, cyc});
    end
  end

  // Present one pixel and hold it until ready; 'at' is the cycle count of the accepting negedge
  task automatic drv(input bit sel, input logic [7:0] d, input logic s, output int at);
    int n = 0;
    @(negedge clk);
    if (sel) begin b_valid = 1'b1; b_pix = d; b_sof = s; end
    else     begin a_valid = 1'b1; a_pix = d; a_sof = s; end
    while (((sel ? b_rdy : a_rdy) !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL drv_timeout: pix_ready got 0 want 1 within 100 cycles");
    end
    at = cyc;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    a_valid = 1'b0; a_sof = 1'b0; b_valid = 1'b0; b_sof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic collect(input bit sel);
    epos.delete();
    if (sel) begin foreach (qb[i]) if (qb[i].en === 1'b1) epos.push_back(i); end
    else     begin foreach (qa[i]) if (qa[i].en === 1'b1) epos.push_back(i); end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; a_pix = 8'h5A; a_sof = 1'b1;
    b_valid = 1'b0; b_pix = 8'h00; b_sof = 1'b0;
    #12;
    n_cmp++; if (a_en !== 1'b0)  begin n_err++; $display("FAIL rst_enable: got %b want 0", a_en); end
    n_cmp++; if (a_ima !== 8'h0) begin n_err++; $display("FAIL rst_ima: got %h want 00", a_ima); end
    n_cmp++; if ({a_fs, a_ls, a_fe, a_se} !== 4'b0)
      begin n_err++; $display("FAIL rst_flags: got %b want 0000", {a_fs, a_ls, a_fe, a_se}); end
    n_cmp++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", a_rdy); end
    n_cmp++; if (b_rdy !== 1'b0) begin n_err++; $display("FAIL rst_ready_b: got %b want 0", b_rdy); end
    @(negedge clk); a_valid = 1'b0; a_sof = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", a_rdy); end
  endtask

  task automatic test_frame();
    int at, t0, bv, bl, bf, be, bs, bg;
    qa.delete(); rec_on = 1'b1;
    for (int i = 0; i < 224; i++) begin
      drv(1'b0, 8'(i), (i == 0), at);
      if (i == 0) t0 = at;
    end
    idle(20); rec_on = 1'b0; collect(1'b0);
    n_cmp++; if (epos.size() != 224) begin n_err++; $display("FAIL frame_count: got %0d want 224", epos.size()); end
    bs = 0;
    foreach (qa[i]) if (qa[i].se !== 1'b0) bs++;
    n_cmp++; if (bs != 0) begin n_err++; $display("FAIL frame_sync_err: got %0d pulses want 0", bs); end
    if (epos.size() == 224) begin
      bv = 0; bl = 0; bf = 0; be = 0; bg = 0;
      for (int k = 0; k < 224; k++) begin
        if (qa[epos[k]].d !== 8'(k)) bv++;
        if (qa[epos[k]].ls !== ((k % 32) == 0)) bl++;
        if (qa[epos[k]].fs !== (k == 0)) bf++;
        if (qa[epos[k]].fe !== (k == 223)) be++;
        if (k > 0 && (k % 32) != 0 && epos[k] - epos[k-1] != 1) bg++;
      end
      n_cmp++; if (bv != 0) begin n_err++; $display("FAIL frame_values: got %0d wrong want 0", bv); end
      n_cmp++; if (bl != 0) begin n_err++; $display("FAIL frame_line_start: got %0d wrong want 0", bl); end
      n_cmp++; if (bf != 0) begin n_err++; $display("FAIL frame_start: got %0d wrong want 0", bf); end
      n_cmp++; if (be != 0) begin n_err++; $display("FAIL frame_end: got %0d wrong want 0", be); end
      n_cmp++; if (bg != 0) begin n_err++; $display("FAIL frame_inline_gaps: got %0d want 0", bg); end
      for (int j = 1; j < 7; j++) begin
        n_cmp++;
        if (epos[32*j] - epos[32*j-1] - 1 != 2)
          begin n_err++; $display("FAIL hblank_line%0d: got %0d idle want 2", j, epos[32*j] - epos[32*j-1] - 1); end
      end
      n_cmp++; if (qa[epos[0]].cyc != t0 + 2)
        begin n_err++; $display("FAIL first_latency: got %0d want %0d", qa[epos[0]].cyc - t0, 2); end
      n_cmp++; if (qa[epos[32]-1].d !== 8'd31)
        begin n_err++; $display("FAIL ima_hold: got %h want 1f", qa[epos[32]-1].d); end
    end
  endtask

  task automatic test_backpressure();
    int at, t0, lo, rise, bv, bg;
    qa.delete(); rec_on = 1'b1;
    for (int i = 0; i < 224; i++) begin
      drv(1'b0, 8'(223 - i), (i == 0), at);
      if (i == 0) t0 = at;
    end
    idle(20); rec_on = 1'b0; collect(1'b0);
    lo = 0; rise = 0;
    foreach (qa[i]) begin
      if (qa[i].rdy === 1'b0) lo++;
      if (i > 0 && qa[i-1].rdy === 1'b0 && qa[i].rdy === 1'b1) rise++;
    end
    n_cmp++; if (lo == 0)   begin n_err++; $display("FAIL bp_ready_low: got %0d low cycles want >0", lo); end
    n_cmp++; if (rise == 0) begin n_err++; $display("FAIL bp_ready_resume: got %0d rises want >0", rise); end
    n_cmp++; if (epos.size() != 224) begin n_err++; $display("FAIL bp_count: got %0d want 224", epos.size()); end
    if (epos.size() == 224) begin
      bv = 0; bg = 0;
      for (int k = 0; k < 224; k++) begin
        if (qa[epos[k]].d !== 8'(223 - k)) bv++;
        if (k > 0 && epos[k] - epos[k-1] != (((k % 32) == 0) ? 3 : 1)) bg++;
      end
      n_cmp++; if (bv != 0) begin n_err++; $display("FAIL bp_order: got %0d wrong want 0", bv); end
      n_cmp++; if (bg != 0) begin n_err++; $display("FAIL bp_gaps: got %0d wrong want 0", bg); end
      n_cmp++; if (qa[epos[0]].cyc != t0 + 2)
        begin n_err++; $display("FAIL bp_latency: got %0d want 2", qa[epos[0]].cyc - t0); end
    end
  endtask

  task automatic test_drop_sof();
    int at, nfe;
    qa.delete(); rec_on = 1'b1;
    for (int i = 0; i < 5; i++) drv(1'b0, 8'(8'hA0 + i), 1'b0, at);
    for (int i = 0; i < 224; i++) drv(1'b0, 8'(i), (i == 0), at);
    idle(20); rec_on = 1'b0; collect(1'b0);
    n_cmp++; if (epos.size() != 224) begin n_err++; $display("FAIL drop_count: got %0d want 224", epos.size()); end
    if (epos.size() > 0) begin
      n_cmp++; if (qa[epos[0]].d !== 8'd0) begin n_err++; $display("FAIL drop_first: got %h want 00", qa[epos[0]].d); end
      n_cmp++; if (qa[epos[0]].fs !== 1'b1) begin n_err++; $display("FAIL drop_fs: got %b want 1", qa[epos[0]].fs); end
    end
    nfe = 0;
    foreach (qa[i]) if (qa[i].fe === 1'b1) nfe++;
    n_cmp++; if (nfe != 1) begin n_err++; $display("FAIL drop_fe: got %0d want 1", nfe); end
  endtask

  task automatic test_early_sof();
    int at, nse, nfs, nfe, bv;
    qa.delete(); rec_on = 1'b1;
    for (int i = 0; i < 40; i++)  drv(1'b0, 8'(100 + i), (i == 0), at);
    for (int i = 0; i < 224; i++) drv(1'b0, 8'(i), (i == 0), at);
    idle(20); rec_on = 1'b0; collect(1'b0);
    nse = 0; nfs = 0; nfe = 0;
    foreach (qa[i]) begin
      if (qa[i].se === 1'b1) nse++;
      if (qa[i].fs === 1'b1) nfs++;
      if (qa[i].fe === 1'b1) nfe++;
    end
    n_cmp++; if (epos.size() != 264) begin n_err++; $display("FAIL early_count: got %0d want 264", epos.size()); end
    n_cmp++; if (nse != 1) begin n_err++; $display("FAIL early_se_count: got %0d want 1", nse); end
    n_cmp++; if (nfs != 2) begin n_err++; $display("FAIL early_fs_count: got %0d want 2", nfs); end
    n_cmp++; if (nfe != 1) begin n_err++; $display("FAIL early_fe_count: got %0d want 1", nfe); end
    if (epos.size() == 264) begin
      n_cmp++; if ({qa[epos[40]].se, qa[epos[40]].fs, qa[epos[40]].ls} !== 3'b111)
        begin n_err++; $display("FAIL early_flags: got %b want 111", {qa[epos[40]].se, qa[epos[40]].fs, qa[epos[40]].ls}); end
      n_cmp++; if (qa[epos[263]].fe !== 1'b1) begin n_err++; $display("FAIL early_fe_pos: got %b want 1", qa[epos[263]].fe); end
      bv = 0;
      for (int k = 0; k < 224; k++) if (qa[epos[40+k]].d !== 8'(k)) bv++;
      n_cmp++; if (bv != 0) begin n_err++; $display("FAIL early_values: got %0d wrong want 0", bv); end
    end
  endtask

  task automatic test_reset_mid();
    int at;
    for (int i = 0; i < 12; i++) drv(1'b0, 8'(i + 1), (i == 0), at);
    @(posedge clk); #2;
    n_cmp++; if ({a_en, a_ima} !== {1'b1, 8'd11})
      begin n_err++; $display("FAIL mid_pre: got en=%b ima=%h want en=1 ima=0b", a_en, a_ima); end
    rst = 1'b1; #1;
    n_cmp++; if ({a_en, a_ima} !== 9'h0) begin n_err++; $display("FAIL mid_rst_out: got en=%b ima=%h want 0", a_en, a_ima); end
    n_cmp++; if ({a_fs, a_ls, a_fe, a_se} !== 4'b0) begin n_err++; $display("FAIL mid_rst_flags: got %b want 0000", {a_fs, a_ls, a_fe, a_se}); end
    n_cmp++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", a_rdy); end
    @(negedge clk); a_valid = 1'b0; a_sof = 1'b0;
    @(negedge clk); rst = 1'b0;
    qa.delete(); rec_on = 1'b1;
    for (int i = 0; i < 3; i++) drv(1'b0, 8'(8'h50 + i), 1'b0, at);
    for (int i = 0; i < 4; i++) drv(1'b0, 8'(8'h60 + i), (i == 0), at);
    idle(10); rec_on = 1'b0; collect(1'b0);
    n_cmp++; if (epos.size() != 4) begin n_err++; $display("FAIL mid_post_count: got %0d want 4", epos.size()); end
    if (epos.size() > 0) begin
      n_cmp++; if ({qa[epos[0]].fs, qa[epos[0]].d} !== {1'b1, 8'h60})
        begin n_err++; $display("FAIL mid_post_first: got fs=%b d=%h want fs=1 d=60", qa[epos[0]].fs, qa[epos[0]].d); end
    end
  endtask

  task automatic test_hblank0();
    int at, bad;
    qb.delete(); rec_on = 1'b1;
    for (int i = 0; i < 8; i++) drv(1'b1, 8'(10 + i), (i == 0), at);
    idle(10); rec_on = 1'b0; collect(1'b1);
    n_cmp++; if (epos.size() != 8) begin n_err++; $display("FAIL hb0_count: got %0d want 8", epos.size()); end
    if (epos.size() == 8) begin
      n_cmp++; if (epos[7] - epos[0] != 7) begin n_err++; $display("FAIL hb0_contig: got span %0d want 7", epos[7] - epos[0]); end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        if (qb[epos[k]].d !== 8'(10 + k)) bad++;
        if (qb[epos[k]].ls !== (k == 0 || k == 4)) bad++;
        if (qb[epos[k]].fe !== (k == 7)) bad++;
        if (qb[epos[k]].fs !== (k == 0)) bad++;
      end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hb0_marks: got %0d wrong want 0", bad); end
    end
  endtask

  initial begin
    a_pix = '0; a_sof = 1'b0; a_valid = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_drop_sof();
    test_early_sof();
    test_hblank0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    n_err++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
